// File: rtl/rs_tagged_multicdb.sv
// rtl/rs_tagged_multicdb.sv - reservation station with age-matrix oldest-ready select
// and multi-channel CDB wakeup feeding a registered issue port.
module rs_tagged_multicdb #(
  parameter int DEPTH   = 16,
  parameter int NUM_CDB = 3,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int OP_W    = 6,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [OP_W-1:0]          alloc_op,
  input  logic [XLEN-1:0]          alloc_vj,
  input  logic [XLEN-1:0]          alloc_vk,
  input  logic                     alloc_qj_busy,
  input  logic                     alloc_qk_busy,
  input  logic [TAG_W-1:0]         alloc_qj,
  input  logic [TAG_W-1:0]         alloc_qk,
  input  logic [XLEN-1:0]          alloc_imm,
  input  logic [XLEN-1:0]          alloc_pc,
  input  logic [TAG_W-1:0]         alloc_rob,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [OP_W-1:0]          iss_op,
  output logic [XLEN-1:0]          iss_vj,
  output logic [XLEN-1:0]          iss_vk,
  output logic [XLEN-1:0]          iss_imm,
  output logic [XLEN-1:0]          iss_pc,
  output logic [TAG_W-1:0]         iss_rob,
  output logic [CNT_W-1:0]         count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] qj_busy;
  logic [DEPTH-1:0] qk_busy;
  logic [DEPTH-1:0] older [DEPTH];
  logic [DEPTH-1:0] older_col [DEPTH];

  logic [OP_W-1:0]  e_op  [DEPTH];
  logic [XLEN-1:0]  e_vj  [DEPTH];
  logic [XLEN-1:0]  e_vk  [DEPTH];
  logic [XLEN-1:0]  e_imm [DEPTH];
  logic [XLEN-1:0]  e_pc  [DEPTH];
  logic [TAG_W-1:0] e_qj  [DEPTH];
  logic [TAG_W-1:0] e_qk  [DEPTH];
  logic [TAG_W-1:0] e_rob [DEPTH];

  logic [DEPTH-1:0] hit_j;
  logic [DEPTH-1:0] hit_k;
  logic [DEPTH-1:0] wake_j;
  logic [DEPTH-1:0] wake_k;
  logic [XLEN-1:0]  wval_j [DEPTH];
  logic [XLEN-1:0]  wval_k [DEPTH];
  logic             byp_hit_j;
  logic             byp_hit_k;
  logic [XLEN-1:0]  byp_val_j;
  logic [XLEN-1:0]  byp_val_k;

  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] sel_vec;
  logic             sel_any;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             alloc_fire;
  logic             iss_load;
  logic             iss_take;

  // Lowest channel index wins when several channels carry the same tag.
  function automatic logic [XLEN:0] snoop(input logic [TAG_W-1:0] tag);
    logic [XLEN:0] r;
    r = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdb_valid[k] && (cdb_tag[k*TAG_W +: TAG_W] == tag))
        r = {1'b1, cdb_value[k*XLEN +: XLEN]};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {hit_j[i], wval_j[i]} = snoop(e_qj[i]);
      {hit_k[i], wval_k[i]} = snoop(e_qk[i]);
    end
    {byp_hit_j, byp_val_j} = snoop(alloc_qj);
    {byp_hit_k, byp_val_k} = snoop(alloc_qk);
  end

  assign wake_j = busy & qj_busy & hit_j;
  assign wake_k = busy & qk_busy & hit_k;
  assign ready  = busy & ~qj_busy & ~qk_busy;

  // older[i][j] set means entry i was allocated before entry j.
  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++)
        older_col[i][j] = older[j][i];
    end
    for (int i = 0; i < DEPTH; i++)
      sel_vec[i] = ready[i] && !(|(ready & older_col[i]));
  end

  always_comb begin
    sel_any = |sel_vec;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_vec[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  assign alloc_ready = rdy && !flush && (count < CNT_W'(DEPTH));
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign iss_load    = !iss_valid || iss_ready;
  assign iss_take    = iss_load && sel_any;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= '0;
      qj_busy   <= '0;
      qk_busy   <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      iss_valid <= 1'b0;
      iss_op    <= '0;
      iss_vj    <= '0;
      iss_vk    <= '0;
      iss_imm   <= '0;
      iss_pc    <= '0;
      iss_rob   <= '0;
      count     <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy      <= '0;
        iss_valid <= 1'b0;
        count     <= '0;
      end else begin
        if (iss_load) begin
          if (sel_any) begin
            iss_valid      <= 1'b1;
            iss_op         <= e_op[sel_idx];
            iss_vj         <= e_vj[sel_idx];
            iss_vk         <= e_vk[sel_idx];
            iss_imm        <= e_imm[sel_idx];
            iss_pc         <= e_pc[sel_idx];
            iss_rob        <= e_rob[sel_idx];
            busy[sel_idx]  <= 1'b0;
          end else begin
            iss_valid <= 1'b0;
          end
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (wake_j[i]) qj_busy[i] <= 1'b0;
          if (wake_k[i]) qk_busy[i] <= 1'b0;
        end
        if (alloc_fire) begin
          busy[free_idx]    <= 1'b1;
          qj_busy[free_idx] <= alloc_qj_busy && !byp_hit_j;
          qk_busy[free_idx] <= alloc_qk_busy && !byp_hit_k;
          older[free_idx]   <= '0;
          for (int j = 0; j < DEPTH; j++) begin
            if (IDX_W'(j) != free_idx) older[j][free_idx] <= 1'b1;
          end
        end
        count <= count + CNT_W'(alloc_fire) - CNT_W'(iss_take);
      end
    end
  end

  // Payload carries no reset: busy/qj_busy/qk_busy alone decide validity.
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wake_j[i]) e_vj[i] <= wval_j[i];
        if (wake_k[i]) e_vk[i] <= wval_k[i];
      end
      if (alloc_fire) begin
        e_op[free_idx]  <= alloc_op;
        e_vj[free_idx]  <= (alloc_qj_busy && byp_hit_j) ? byp_val_j : alloc_vj;
        e_vk[free_idx]  <= (alloc_qk_busy && byp_hit_k) ? byp_val_k : alloc_vk;
        e_imm[free_idx] <= alloc_imm;
        e_pc[free_idx]  <= alloc_pc;
        e_qj[free_idx]  <= alloc_qj;
        e_qk[free_idx]  <= alloc_qk;
        e_rob[free_idx] <= alloc_rob;
      end
    end
  end

endmodule

// File: tb/tb_rs_tagged_multicdb.sv
// tb/tb_rs_tagged_multicdb.sv - directed and randomized checks of rs_tagged_multicdb
// against an age-queue reference model.
module tb_rs_tagged_multicdb;

  localparam int DEPTH   = 4;
  localparam int NUM_CDB = 3;
  localparam int XLEN    = 32;
  localparam int TAG_W   = 5;
  localparam int OP_W    = 6;
  localparam int CNT_W   = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     rdy = 1'b1;
  logic                     flush = 1'b0;
  logic                     alloc_valid = 1'b0;
  logic                     alloc_ready;
  logic [OP_W-1:0]          alloc_op = '0;
  logic [XLEN-1:0]          alloc_vj = '0;
  logic [XLEN-1:0]          alloc_vk = '0;
  logic                     alloc_qj_busy = 1'b0;
  logic                     alloc_qk_busy = 1'b0;
  logic [TAG_W-1:0]         alloc_qj = '0;
  logic [TAG_W-1:0]         alloc_qk = '0;
  logic [XLEN-1:0]          alloc_imm = '0;
  logic [XLEN-1:0]          alloc_pc = '0;
  logic [TAG_W-1:0]         alloc_rob = '0;
  logic [NUM_CDB-1:0]       cdb_valid = '0;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag = '0;
  logic [NUM_CDB*XLEN-1:0]  cdb_value = '0;
  logic                     iss_valid;
  logic                     iss_ready = 1'b1;
  logic [OP_W-1:0]          iss_op;
  logic [XLEN-1:0]          iss_vj;
  logic [XLEN-1:0]          iss_vk;
  logic [XLEN-1:0]          iss_imm;
  logic [XLEN-1:0]          iss_pc;
  logic [TAG_W-1:0]         iss_rob;
  logic [CNT_W-1:0]         count;

  always #5 clk = ~clk;

  rs_tagged_multicdb #(
    .DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
    .alloc_vj(alloc_vj), .alloc_vk(alloc_vk),
    .alloc_qj_busy(alloc_qj_busy), .alloc_qk_busy(alloc_qk_busy),
    .alloc_qj(alloc_qj), .alloc_qk(alloc_qk),
    .alloc_imm(alloc_imm), .alloc_pc(alloc_pc), .alloc_rob(alloc_rob),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_imm(iss_imm), .iss_pc(iss_pc),
    .iss_rob(iss_rob), .count(count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: entries plus an explicit oldest-first list of busy indices.
  typedef struct {
    bit             busy;
    bit [OP_W-1:0]  op;
    bit [XLEN-1:0]  vj, vk, imm, pc;
    bit             qjb, qkb;
    bit [TAG_W-1:0] qj, qk, rob;
  } ent_t;

  ent_t           m_e [DEPTH];
  int             m_age [$];
  bit             m_iv;
  bit [OP_W-1:0]  m_op;
  bit [XLEN-1:0]  m_vj, m_vk, m_imm, m_pc;
  bit [TAG_W-1:0] m_rob;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_e[i].busy) c++;
    return c;
  endfunction

  function automatic bit cdb_lookup(input bit [TAG_W-1:0] tag, output bit [XLEN-1:0] val);
    val = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == tag) begin
        val = cdb_value[k*XLEN +: XLEN];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_e[i].busy = 0;
    m_age.delete();
    m_iv = 0; m_op = '0; m_vj = '0; m_vk = '0; m_imm = '0; m_pc = '0; m_rob = '0;
  endtask

  task automatic model_step();
    int            fr, sel, e;
    bit            do_alloc;
    bit [XLEN-1:0] v;
    if (!rdy) return;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_e[i].busy = 0;
      m_age.delete();
      m_iv = 0;
      return;
    end
    fr = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_e[i].busy) fr = i;
    do_alloc = alloc_valid && (m_count() < DEPTH);
    sel = -1;
    for (int p = 0; p < m_age.size(); p++) begin
      e = m_age[p];
      if (sel < 0 && !m_e[e].qjb && !m_e[e].qkb) sel = p;
    end
    if (!m_iv || iss_ready) begin
      if (sel >= 0) begin
        e = m_age[sel];
        m_iv = 1; m_op = m_e[e].op; m_vj = m_e[e].vj; m_vk = m_e[e].vk;
        m_imm = m_e[e].imm; m_pc = m_e[e].pc; m_rob = m_e[e].rob;
        m_e[e].busy = 0;
        m_age.delete(sel);
      end else begin
        m_iv = 0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_e[i].busy && m_e[i].qjb && cdb_lookup(m_e[i].qj, v)) begin m_e[i].vj = v; m_e[i].qjb = 0; end
      if (m_e[i].busy && m_e[i].qkb && cdb_lookup(m_e[i].qk, v)) begin m_e[i].vk = v; m_e[i].qkb = 0; end
    end
    if (do_alloc) begin
      m_e[fr].busy = 1; m_e[fr].op = alloc_op; m_e[fr].imm = alloc_imm;
      m_e[fr].pc = alloc_pc; m_e[fr].rob = alloc_rob;
      m_e[fr].qj = alloc_qj; m_e[fr].qk = alloc_qk;
      m_e[fr].vj = alloc_vj; m_e[fr].vk = alloc_vk;
      m_e[fr].qjb = alloc_qj_busy; m_e[fr].qkb = alloc_qk_busy;
      if (alloc_qj_busy && cdb_lookup(alloc_qj, v)) begin m_e[fr].vj = v; m_e[fr].qjb = 0; end
      if (alloc_qk_busy && cdb_lookup(alloc_qk, v)) begin m_e[fr].vk = v; m_e[fr].qkb = 0; end
      m_age.push_back(fr);
    end
  endtask

  task automatic check_model();
    chk("iss_valid", iss_valid, m_iv);
    chk("count", count, m_count());
    chk("alloc_ready", alloc_ready, rdy && !flush && (m_count() < DEPTH));
    if (m_iv) begin
      chk("iss_op", iss_op, m_op);
      chk("iss_vj", iss_vj, m_vj);
      chk("iss_vk", iss_vk, m_vk);
      chk("iss_imm", iss_imm, m_imm);
      chk("iss_pc", iss_pc, m_pc);
      chk("iss_rob", iss_rob, m_rob);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic set_idle();
    alloc_valid = 0; cdb_valid = '0; flush = 0; rdy = 1; iss_ready = 1;
  endtask

  task automatic do_alloc(input int op, input int vj, input int vk, input bit qjb, input int qj,
                          input bit qkb, input int qk, input int rob);
    alloc_valid = 1; alloc_op = OP_W'(op); alloc_vj = XLEN'(vj); alloc_vk = XLEN'(vk);
    alloc_qj_busy = qjb; alloc_qj = TAG_W'(qj); alloc_qk_busy = qkb; alloc_qk = TAG_W'(qk);
    alloc_imm = XLEN'(rob * 16); alloc_pc = XLEN'(32'h1000 + rob * 4); alloc_rob = TAG_W'(rob);
  endtask

  task automatic set_cdb(input int k, input int tag, input int val);
    cdb_valid[k] = 1'b1;
    cdb_tag[k*TAG_W +: TAG_W] = TAG_W'(tag);
    cdb_value[k*XLEN +: XLEN] = XLEN'(val);
  endtask

  initial begin
    model_reset();
    #1;
    chk("reset_iss_valid", iss_valid, 0);
    chk("reset_count", count, 0);
    chk("reset_alloc_ready", alloc_ready, 1);
    chk("reset_iss_rob", iss_rob, 0);
    @(negedge clk);
    rst = 1;

    // Both sources ready: issued after the edge following the alloc edge.
    set_idle();
    do_alloc(1, 5, 7, 0, 0, 0, 0, 3);
    tick();
    alloc_valid = 0;
    chk("t1_count_after_alloc", count, 1);
    chk("t1_not_yet_issued", iss_valid, 0);
    tick();
    chk("t1_iss_valid", iss_valid, 1);
    chk("t1_iss_vj", iss_vj, 5);
    chk("t1_iss_vk", iss_vk, 7);
    chk("t1_iss_rob", iss_rob, 3);
    chk("t1_count_zero", count, 0);
    tick();
    chk("t1_drained", iss_valid, 0);

    // Older waiting entry is overtaken by a younger ready one.
    do_alloc(2, 0, 11, 1, 9, 0, 0, 1);
    tick();
    do_alloc(3, 20, 21, 0, 0, 0, 0, 2);
    tick();
    alloc_valid = 0;
    set_cdb(1, 9, 32'h1234);
    tick();
    cdb_valid = '0;
    chk("t2_first_rob", iss_rob, 2);
    chk("t2_first_vj", iss_vj, 20);
    tick();
    chk("t2_second_rob", iss_rob, 1);
    chk("t2_second_vj", iss_vj, 32'h1234);
    chk("t2_second_vk", iss_vk, 11);
    tick();

    // Allocation bypass of both sources from one channel.
    do_alloc(4, 0, 0, 1, 4, 1, 4, 4);
    set_cdb(0, 4, 32'hAA);
    tick();
    alloc_valid = 0; cdb_valid = '0;
    tick();
    chk("t3_iss_valid", iss_valid, 1);
    chk("t3_iss_vj", iss_vj, 32'hAA);
    chk("t3_iss_vk", iss_vk, 32'hAA);
    tick();

    // Fill, rejected extra alloc, then wake entry 2.
    for (int i = 0; i < DEPTH; i++) begin
      do_alloc(5, 0, 1, 1, 10 + i, 0, 0, i);
      tick();
    end
    alloc_valid = 0;
    chk("t4_full_count", count, 4);
    chk("t4_full_alloc_ready", alloc_ready, 0);
    do_alloc(6, 1, 1, 0, 0, 0, 0, 9);
    tick();
    alloc_valid = 0;
    chk("t4_ignored_count", count, 4);
    set_cdb(2, 12, 32'h55);
    tick();
    cdb_valid = '0;
    tick();
    chk("t4_wake_rob", iss_rob, 2);
    chk("t4_wake_vj", iss_vj, 32'h55);
    chk("t4_count_after", count, 3);
    chk("t4_alloc_ready_after", alloc_ready, 1);
    flush = 1;
    tick();
    flush = 0;

    // Back-pressure holds the issue register.
    iss_ready = 0;
    do_alloc(7, 50, 51, 0, 0, 0, 0, 5);
    tick();
    do_alloc(7, 60, 61, 0, 0, 0, 0, 6);
    tick();
    alloc_valid = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t5_hold_rob", iss_rob, 5);
      chk("t5_hold_vj", iss_vj, 50);
      chk("t5_hold_count", count, 1);
    end
    iss_ready = 1;
    tick();
    chk("t5_next_rob", iss_rob, 6);
    chk("t5_next_count", count, 0);
    tick();

    // Flush with busy entries and a full issue register.
    iss_ready = 0;
    do_alloc(8, 32'h77, 1, 0, 0, 0, 0, 7);
    tick();
    do_alloc(8, 0, 0, 1, 20, 0, 0, 8);
    tick();
    do_alloc(8, 0, 0, 1, 21, 0, 0, 9);
    tick();
    do_alloc(8, 0, 0, 1, 22, 0, 0, 10);
    tick();
    alloc_valid = 0;
    chk("t6_pre_count", count, 3);
    chk("t6_pre_iss_valid", iss_valid, 1);
    flush = 1;
    tick();
    flush = 0;
    chk("t6_flush_count", count, 0);
    chk("t6_flush_iss_valid", iss_valid, 0);

    // Asynchronous reset between edges while a wakeup is on the bus.
    iss_ready = 1;
    do_alloc(9, 0, 0, 1, 23, 0, 0, 11);
    tick();
    alloc_valid = 0;
    set_cdb(0, 23, 32'h99);
    #2;
    rst = 0;
    #1;
    chk("t7_rst_iss_valid", iss_valid, 0);
    chk("t7_rst_count", count, 0);
    chk("t7_rst_iss_vj", iss_vj, 0);
    chk("t7_rst_iss_rob", iss_rob, 0);
    chk("t7_rst_alloc_ready", alloc_ready, 1);
    model_reset();
    @(negedge clk);
    rst = 1;
    cdb_valid = '0;

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 79) == 0);
      iss_ready = ($urandom_range(0, 3) != 0);
      do_alloc($urandom_range(0, 63), $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 7),
               $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 31));
      alloc_valid = $urandom_range(0, 1);
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb_valid[k] = ($urandom_range(0, 2) == 0);
        cdb_tag[k*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
        cdb_value[k*XLEN +: XLEN] = $urandom;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
